// File: rtl/gpr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpr_sched_pkg
// Description : Shared constants and types for the GPR write-port scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package gpr_sched_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_MD   = 2'd2
    } grant_e;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } md_entry_t;

endpackage
`default_nettype wire

// File: rtl/gpr_md_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gpr_md_fifo
// Description : DEPTH-entry FIFO of mult/div results awaiting the GPR port.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_md_fifo
    import gpr_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  md_entry_t i_push_data,
    input  logic      i_pop,
    output md_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    md_entry_t          r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_ptr_w'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage carries no reset; occupancy is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpr_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : gpr_write_sched
// Description : Shares the GPR write port between WB and the mult/div unit and
//               scoreboards pending MD writes. Optional anti-starvation hold is
//               enabled by defining GPR_SCHED_STARVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_write_sched
    import gpr_sched_pkg::*;
#(
    parameter int NREG         = 32,
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_wa,
    input  logic [DW-1:0]   wb_wd,
    input  logic            md_issue,
    input  logic [AW-1:0]   md_rd,
    input  logic            md_valid,
    output logic            md_ready,
    input  logic [AW-1:0]   md_wa,
    input  logic [DW-1:0]   md_wd,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_rd_en,
    output logic            id_stall,
    output logic            wb_hold,
    output logic            gpr_we,
    output logic [AW-1:0]   gpr_wa,
    output logic [DW-1:0]   gpr_wd,
    output logic [NREG-1:0] busy_vec
);

    md_entry_t       w_push_data;
    md_entry_t       w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_wb_req;
    logic            w_wb_hold;
    grant_e          w_grant;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // These branches elaborate only for unusable parameter values.
    if (BUF_DEPTH < 1) begin : g_bad_buf_depth
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    end

    assign w_push_data.wa = md_wa;
    assign w_push_data.wd = md_wd;

    gpr_md_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_md_fifo (
        .clk         (Clk),
        .rst         (Reset),
        .i_push      (md_valid & md_ready),
        .i_push_data (w_push_data),
        .i_pop       (w_grant == GNT_MD),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign md_ready = ~w_full;
    assign w_wb_req = wb_we & (wb_wa != '0);

    always_comb begin
        w_grant = GNT_NONE;
        if (w_wb_hold && !w_empty) begin
            w_grant = GNT_MD;
        end else if (w_wb_req) begin
            w_grant = GNT_WB;
        end else if (!w_empty) begin
            w_grant = GNT_MD;
        end
    end

`ifdef GPR_SCHED_STARVE_EN
    localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);

    logic [c_starve_w-1:0] r_starve_cnt;
    logic                  r_wb_hold;

    // Hold fires the cycle after the count reaches the limit, forcing MD through.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_starve_cnt <= '0;
            r_wb_hold    <= 1'b0;
        end else begin
            r_wb_hold <= 1'b0;
            if (w_grant == GNT_MD) begin
                r_starve_cnt <= '0;
            end else if (!w_empty) begin
                if (r_starve_cnt + 1'b1 == c_starve_w'(STARVE_LIMIT)) begin
                    r_starve_cnt <= '0;
                    r_wb_hold    <= 1'b1;
                end else begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end
        end
    end

    assign w_wb_hold = r_wb_hold;
`else
    assign w_wb_hold = 1'b0;
`endif

    assign wb_hold = w_wb_hold;

    // A new issue to a register wins over the retiring write of an older op.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_grant == GNT_MD) begin
            w_busy_nxt[w_head.wa] = 1'b0;
        end
        if (md_issue) begin
            w_busy_nxt[md_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_busy <= '0;
            gpr_we <= 1'b0;
            gpr_wa <= '0;
            gpr_wd <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            case (w_grant)
                GNT_WB: begin
                    gpr_we <= 1'b1;
                    gpr_wa <= wb_wa;
                    gpr_wd <= wb_wd;
                end
                GNT_MD: begin
                    gpr_we <= 1'b1;
                    gpr_wa <= w_head.wa;
                    gpr_wd <= w_head.wd;
                end
                default: begin
                    gpr_we <= 1'b0;
                    gpr_wa <= '0;
                    gpr_wd <= '0;
                end
            endcase
        end
    end

    assign busy_vec = r_busy;
    assign id_stall = r_busy[id_rs] | r_busy[id_rt] | (id_rd_en & r_busy[id_rd]);

endmodule
`default_nettype wire

// File: doc/gpr_write_sched.md
Name: gpr_write_sched

Overview:
- Write-port scheduler and scoreboard for the 32x32 GPR.
- Shares the single GPR write port between the pipeline WB stage and the multicycle mult/div (MD) unit, which writes its result straight to a GPR.
- Buffers MD results and tracks registers with pending MD writes.
- Drives a decode-stage stall on RAW or WAW hazards against those pending writes.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register address width.
- DW, 32, data width.
- BUF_DEPTH, 2, MD result buffer entries (power of 2, at least 1).
- STARVE_LIMIT, 8, cycles an MD entry may wait before forced grant (macro build only).

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- wb_we  in  1  WB stage write request.
- wb_wa  in  AW  WB destination register.
- wb_wd  in  DW  WB write data.
- md_issue  in  1  MD op issued from decode this cycle.
- md_rd  in  AW  destination of the issued MD op.
- md_valid  in  1  MD result valid.
- md_ready  out  1  buffer can accept an MD result.
- md_wa  in  AW  MD result destination.
- md_wd  in  DW  MD result data.
- id_rs  in  AW  decode source 1.
- id_rt  in  AW  decode source 2.
- id_rd  in  AW  decode destination.
- id_rd_en  in  1  decode instruction writes id_rd.
- id_stall  out  1  decode must hold.
- wb_hold  out  1  WB write refused this cycle; pipeline holds WB.
- gpr_we  out  1  GPR write enable.
- gpr_wa  out  AW  GPR write address.
- gpr_wd  out  DW  GPR write data.
- busy_vec  out  NREG  scoreboard, bit i = MD write pending to register i.

Behaviour:
- Reset (clocked, Reset=1): gpr_we=0, gpr_wa=0, gpr_wd=0, busy_vec=0, buffer empty, md_ready=1, wb_hold=0, starve counter=0. Reset mid-operation flushes all buffered MD results; requests presented in the reset cycle are dropped.
- Grant, evaluated each cycle, priority order:
  - 1) wb_hold high and buffer non-empty -> MD.
  - 2) wb_we=1 and wb_wa!=0 -> WB.
  - 3) buffer non-empty -> MD (pop head).
  - 4) otherwise none.
- wb_we with wb_wa=0 is treated as no request and never blocks MD.
- gpr_we/gpr_wa/gpr_wd are registered: a grant in cycle t appears on the outputs in cycle t+1. With no grant, gpr_we=0 and gpr_wa=gpr_wd=0.
- MD handshake: a result is accepted when md_valid && md_ready and pushed at the buffer tail. The earliest grant for it is the next cycle (no bypass).
- md_ready = (count < BUF_DEPTH), from registered state only. When full, md_ready=0 even if a pop happens the same cycle.
- Buffer is strict FIFO with wrap-around pointers and a count of 0..BUF_DEPTH.
- Scoreboard:
  - md_issue with md_rd!=0 sets busy[md_rd].
  - An MD grant clears busy[head.wa].
  - Set and clear of the same index in the same cycle: set wins.
  - busy[0] is always 0.
- id_stall (combinational) = busy[id_rs] | busy[id_rt] | (id_rd_en & busy[id_rd]).
- Protocol violations, flagged by the bench, no RTL recovery:
  - md_issue to a busy register.
  - WB write to a busy register.
  - md_valid for a register that is not busy. The data is still written.

Optional Feature:
- Macro GPR_SCHED_STARVE_EN.
- Defined:
  - A starve counter increments each cycle the buffer is non-empty and MD is not granted.
  - It clears on any MD grant.
  - When it reaches STARVE_LIMIT, wb_hold is registered high for exactly one cycle, and the counter clears.
  - In that cycle MD wins over WB. The WB request is not written; the pipeline re-presents it next cycle.
- Undefined: wb_hold tied to 0, no counter, and WB always has priority.

Decomposition:
- Package gpr_sched_pkg holds:
  - AW, DW, NREG constants.
  - Grant enum {GNT_NONE, GNT_WB, GNT_MD}.
  - MD entry struct {wa, wd}.
- Sub-module gpr_md_fifo: the BUF_DEPTH-entry FIFO with push/pop/count/full/empty. Scoreboard, arbitration and starve logic stay in the top.

Test Plan:
- Reset: after Reset held high for 2 cycles, check gpr_we=0, busy_vec=0, md_ready=1, id_stall=0. Then issue Reset mid-operation with 2 buffered entries -> buffer empty and busy_vec=0 on the next cycle.
- Scoreboard stall:
  - md_issue md_rd=8 -> busy_vec[8]=1.
  - id_rs=8 -> id_stall=1.
  - md_valid md_wa=8 md_wd=0x1234 with wb_we=0 -> gpr_we=1, gpr_wa=8, gpr_wd=0x1234 two cycles after acceptance; busy[8]=0 and id_stall=0 after that grant.
- Contention:
  - MD result (wa=9) buffered while wb_we=1 (wb_wa=3) for 3 cycles -> only WB writes appear.
  - MD write to 9 appears in the cycle after wb_we drops.
  - wb_wa=0 with wb_we=1 does not block MD.
- Full buffer:
  - Push results for 10 and 11 while WB is saturated -> md_ready=0.
  - Third md_valid held until a pop.
  - Writes occur in order 10, 11, 12.
- Simultaneous set/clear: md_issue md_rd=5 in the same cycle as the MD grant of an old entry for 5 -> busy[5] stays 1.
- GPR_SCHED_STARVE_EN with STARVE_LIMIT=8: WB is continuously writing and one MD entry is pending -> wb_hold=1 for one cycle after 8 waiting cycles, and the MD write is granted in that cycle.
